// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream bundle with master/slave modports.
// Signals: tvalid/tready handshake, tdata, tkeep, tstrb, tlast, tid, tdest, tuser.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;
    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_stream_pkt_defrag.sv
// axi4_stream_pkt_defrag: merges byte fragments into full-width packet beats.
// Ports: clk_i clock; rst_i async active-high reset;
//        pkt_i fragment stream in (tuser[0] on tlast marks end of packet);
//        pkt_o packet stream out (tuser[0] mirrors tlast).
module axi4_stream_pkt_defrag #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
) (
    input logic            clk_i,
    input logic            rst_i,
    axi4_stream_if.slave   pkt_i,
    axi4_stream_if.master  pkt_o
);
    localparam int W  = TDATA_WIDTH / 8;
    localparam int CW = $clog2(2 * W + 1);
    localparam logic [CW-1:0] WC = CW'(W);

    logic [16*W-1:0]        data_q, data_d, in_data, byte_mask;
    logic [2*W-1:0]         keep_q, keep_d, strb_q, strb_d, in_keep, in_strb, wmask;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_s, n, take;
    logic                   flush_q, flush_d, first_q, first_d;
    logic [TID_WIDTH-1:0]   id_q, id_d;
    logic [TDEST_WIDTH-1:0] dest_q, dest_d;
    logic [TUSER_WIDTH-1:0] user_q, user_d;
    logic                   rx, tx, eop;

    always_comb begin
        n = '0;
        for (int i = 0; i < W; i++) n = n + CW'(pkt_i.tkeep[i]);
        take         = (cnt_q >= WC) ? WC : cnt_q;
        pkt_i.tready = !flush_q && (cnt_q <= WC);
        pkt_o.tvalid = (cnt_q >= WC) || (flush_q && cnt_q != '0);
        pkt_o.tlast  = flush_q && (cnt_q <= WC);
        rx           = pkt_i.tvalid && pkt_i.tready;
        tx           = pkt_o.tvalid && pkt_o.tready;
        eop          = pkt_i.tlast && pkt_i.tuser[0];
        // Output shift happens first, so incoming bytes land after what survives it.
        cnt_s   = tx ? cnt_q - take : cnt_q;
        in_keep = {{W{1'b0}}, pkt_i.tkeep} << cnt_s;
        in_strb = {{W{1'b0}}, pkt_i.tstrb} << cnt_s;
        in_data = {{8*W{1'b0}}, pkt_i.tdata} << {cnt_s, 3'b000};
        wmask   = rx ? in_keep : '0;
        byte_mask = '0;
        for (int j = 0; j < 2 * W; j++) byte_mask[8*j +: 8] = {8{wmask[j]}};
        data_d  = ((tx ? data_q >> (8 * W) : data_q) & ~byte_mask) | (in_data & byte_mask);
        keep_d  = ((tx ? keep_q >> W : keep_q) & ~wmask) | (in_keep & wmask);
        strb_d  = ((tx ? strb_q >> W : strb_q) & ~wmask) | (in_strb & wmask);
        cnt_d   = rx ? cnt_s + n : cnt_s;
        // An empty packet tail leaves nothing to emit, so flush ends on its own.
        flush_d = (rx && eop) ? 1'b1 :
                  ((tx && pkt_o.tlast) || (flush_q && cnt_q == '0)) ? 1'b0 : flush_q;
        first_d = rx ? eop : first_q;
        id_d    = (rx && first_q) ? pkt_i.tid   : id_q;
        dest_d  = (rx && first_q) ? pkt_i.tdest : dest_q;
        user_d  = (rx && first_q) ? pkt_i.tuser : user_q;
    end

    always_comb begin
        pkt_o.tdata = data_q[8*W-1:0];
        pkt_o.tkeep = '0;
        pkt_o.tstrb = '0;
        for (int i = 0; i < W; i++) begin
            pkt_o.tkeep[i] = keep_q[i] && (CW'(i) < take);
            pkt_o.tstrb[i] = strb_q[i] && (CW'(i) < take);
        end
        pkt_o.tid      = id_q;
        pkt_o.tdest    = dest_q;
        pkt_o.tuser    = user_q;
        pkt_o.tuser[0] = pkt_o.tlast;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            keep_q  <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            first_q <= 1'b1;
            id_q    <= '0;
            dest_q  <= '0;
            user_q  <= '0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            first_q <= first_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
        end
    end
endmodule
